// File: rtl/wide_add_pkg.sv
// Shared constants, state encodings and helpers for the wide sequential adder.
package wide_add_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      int unsigned v;
      r = 0;
      v = (n > 0) ? n - 1 : 0;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/adder_32.sv
// 32-bit word adder datapath with carry in and carry out.
module adder_32
   import wide_add_pkg::*;
(
   input  logic [WORD_W-1:0] i_a,
   input  logic [WORD_W-1:0] i_b,
   input  logic              i_cin,
   output logic [WORD_W-1:0] o_sum_c,
   output logic              o_cout_c
);

   logic [WORD_W:0] w_full;

   assign w_full   = {1'b0, i_a} + {1'b0, i_b} + (WORD_W+1)'(i_cin);
   assign o_sum_c  = w_full[WORD_W-1:0];
   assign o_cout_c = w_full[WORD_W];

endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: one 32-bit word per cycle, LS word first, with a carry flop.
// Optional signed-overflow output enabled by defining WIDE_ADD_OVF_EN.
module wide_add_seq
   import wide_add_pkg::*;
#(
   parameter int unsigned NWORDS = 4,
   parameter int unsigned IDX_W  = (clog2(NWORDS) < 1) ? 1 : clog2(NWORDS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WORD_W*NWORDS-1:0]   in_a,
   input  logic [WORD_W*NWORDS-1:0]   in_b,
   input  logic                       in_cin,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WORD_W*NWORDS-1:0]   out_sum,
`ifdef WIDE_ADD_OVF_EN
   output logic                       out_ovf,
`endif
   output logic                       out_cout
);

   localparam int unsigned W = WORD_W * NWORDS;

   state_e             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic               r_carry;
   logic [W-1:0]       r_a;
   logic [W-1:0]       r_b;
   logic [W-1:0]       r_sum;
   logic               r_cout;
   logic               r_valid;
   logic               r_ready;
`ifdef WIDE_ADD_OVF_EN
   logic               r_ovf;
`endif

   logic [WORD_W-1:0]  w_a_word;
   logic [WORD_W-1:0]  w_b_word;
   logic [WORD_W-1:0]  w_sum_word;
   logic               w_cout;
   logic               w_last;

   assign w_a_word = r_a[WORD_W*r_idx +: WORD_W];
   assign w_b_word = r_b[WORD_W*r_idx +: WORD_W];
   assign w_last   = (r_idx == IDX_W'(NWORDS - 1));

   adder_32 u_adder (
      .i_a      (w_a_word),
      .i_b      (w_b_word),
      .i_cin    (r_carry),
      .o_sum_c  (w_sum_word),
      .o_cout_c (w_cout)
   );

   // Control FSM and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_valid <= 1'b0;
         r_ready <= 1'b1;
`ifdef WIDE_ADD_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid && r_ready) begin
                  r_a     <= in_a;
                  r_b     <= in_b;
                  r_carry <= in_cin;
                  r_idx   <= '0;
                  r_sum   <= '0;
                  r_cout  <= 1'b0;
                  r_ready <= 1'b0;
                  r_state <= ST_RUN;
`ifdef WIDE_ADD_OVF_EN
                  r_ovf   <= 1'b0;
`endif
               end
            end
            ST_RUN: begin
               r_sum[WORD_W*r_idx +: WORD_W] <= w_sum_word;
               r_carry <= w_cout;
               if (w_last) begin
                  r_cout  <= w_cout;
                  r_valid <= 1'b1;
                  r_state <= ST_DONE;
`ifdef WIDE_ADD_OVF_EN
                  r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_sum_word[WORD_W-1] != r_a[W-1]);
`endif
               end else begin
                  r_idx <= r_idx + IDX_W'(1);
               end
            end
            ST_DONE: begin
               // Result held until taken; a new op is only accepted from IDLE
               if (out_ready) begin
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_valid <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign in_ready  = r_ready;
   assign out_valid = r_valid;
   assign out_sum   = r_sum;
   assign out_cout  = r_cout;
`ifdef WIDE_ADD_OVF_EN
   assign out_ovf   = r_ovf;
`endif

endmodule
